// File: rtl/justtest1_axil_slave_regs_pkg.sv
// ---------------------------------------------------------------------------
// justtest1_axil_pkg
// Shared types and helpers for the AXI4-Lite slave register file.
//   resp_t      : AXI response codes used on BRESP/RRESP
//   ADDR_LSB    : lowest byte-address bit that selects a register
//   DECERR_DATA : read data returned for out-of-range reads when the
//                 JUSTTEST1_AXIL_DECERR_EN build option is enabled
//   strb_merge  : byte-lane merge of a write into an existing word
// ---------------------------------------------------------------------------
package justtest1_axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_t;

   localparam int          ADDR_LSB    = 2;
   localparam logic [31:0] DECERR_DATA = 32'hDEAD_BEEF;

   // Byte lanes whose strobe bit is set take the new data, the rest keep
   // the old register contents.
   function automatic logic [31:0] strb_merge(input logic [31:0] oldData,
                                              input logic [31:0] newData,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      merged = oldData;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) begin
            merged[8*b +: 8] = newData[8*b +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/justtest1_axil_slave_regs_if.sv
// ---------------------------------------------------------------------------
// justtest1_axil_slave_regs_if
// AXI4-Lite bus bundle between a master and the slave register file.
//   master modport : drives AW/W/AR address, data and VALIDs, B/R READYs
//   slave  modport : drives AW/W/AR READYs, B/R VALIDs, responses, RDATA
// ADDR_WIDTH must match the slave's C_S_AXI_ADDR_WIDTH.
// ---------------------------------------------------------------------------
interface justtest1_axil_slave_regs_if
   import justtest1_axil_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]              S_AXI_AWPROT;
   logic                    S_AXI_AWVALID;
   logic                    S_AXI_AWREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                    S_AXI_WVALID;
   logic                    S_AXI_WREADY;
   resp_t                   S_AXI_BRESP;
   logic                    S_AXI_BVALID;
   logic                    S_AXI_BREADY;
   logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]              S_AXI_ARPROT;
   logic                    S_AXI_ARVALID;
   logic                    S_AXI_ARREADY;
   logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
   resp_t                   S_AXI_RRESP;
   logic                    S_AXI_RVALID;
   logic                    S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

endinterface

// File: rtl/justtest1_axil_slave_regs.sv
// ---------------------------------------------------------------------------
// justtest1_axil_slave_regs
// AXI4-Lite slave holding NUM_REGS 32-bit software registers with byte
// strobed writes. Register contents and per-register write pulses are
// exported to user logic.
// Ports:
//   ACLK, ARESETN : bus clock, asynchronous active-low reset
//   s_axi         : AXI4-Lite slave modport (AW, W, B, AR, R channels)
//   reg_q         : register contents, reg i at bits [32i+31:32i]
//   wr_pulse      : one-cycle pulse the cycle after register i commits
// Build option:
//   JUSTTEST1_AXIL_DECERR_EN : addresses with bits set above the register
//   index answer SLVERR, writes to them are dropped and reads return
//   DECERR_DATA. Without it, upper address bits alias onto the registers.
// Only a 32-bit data bus is supported.
// ---------------------------------------------------------------------------
module justtest1_axil_slave_regs
   import justtest1_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS           = 4
)(
   input  logic                      ACLK,
   input  logic                      ARESETN,
   justtest1_axil_slave_regs_if.slave s_axi,
   output logic [NUM_REGS*32-1:0]    reg_q,
   output logic [NUM_REGS-1:0]       wr_pulse
);

   localparam int IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int UPPER_LSB = ADDR_LSB + IDX_W;

   logic                            r_rstDone;
   logic                            r_awCaptured;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   r_awAddr;
   logic                            r_wCaptured;
   logic [31:0]                     r_wData;
   logic [3:0]                      r_wStrb;
   logic                            r_bValid;
   resp_t                           r_bResp;
   logic                            r_rValid;
   resp_t                           r_rResp;
   logic [31:0]                     r_rData;
   logic [NUM_REGS-1:0]             r_wrPulse;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_regs [NUM_REGS];

   logic                            w_awReady;
   logic                            w_wReady;
   logic                            w_arReady;
   logic                            w_awHs;
   logic                            w_wHs;
   logic                            w_arHs;
   logic                            w_commit;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   w_cmtAddr;
   logic [31:0]                     w_cmtData;
   logic [3:0]                      w_cmtStrb;
   logic [IDX_W-1:0]                w_cmtIdx;
   logic [IDX_W-1:0]                w_arIdx;
   logic                            w_cmtErr;
   logic                            w_arErr;
   logic                            w_unused;

   // READYs come purely from flops so no input reaches an output
   // combinationally; r_rstDone holds them low until the first clock edge
   // after reset release.
   assign w_awReady = r_rstDone && !r_awCaptured && !r_bValid;
   assign w_wReady  = r_rstDone && !r_wCaptured && !r_bValid;
   assign w_arReady = r_rstDone && !r_rValid;

   assign w_awHs = s_axi.S_AXI_AWVALID && w_awReady;
   assign w_wHs  = s_axi.S_AXI_WVALID && w_wReady;
   assign w_arHs = s_axi.S_AXI_ARVALID && w_arReady;

   // A write commits on the edge where the later of AW and W is accepted,
   // taking each half from its holding register or straight off the bus.
   assign w_commit  = (r_awCaptured || w_awHs) && (r_wCaptured || w_wHs);
   assign w_cmtAddr = r_awCaptured ? r_awAddr : s_axi.S_AXI_AWADDR;
   assign w_cmtData = r_wCaptured ? r_wData : s_axi.S_AXI_WDATA;
   assign w_cmtStrb = r_wCaptured ? r_wStrb : s_axi.S_AXI_WSTRB;
   assign w_cmtIdx  = w_cmtAddr[ADDR_LSB +: IDX_W];
   assign w_arIdx   = s_axi.S_AXI_ARADDR[ADDR_LSB +: IDX_W];

   // Out-of-range detection looks only at address bits above the index.
`ifdef JUSTTEST1_AXIL_DECERR_EN
   assign w_cmtErr = |(w_cmtAddr >> UPPER_LSB);
   assign w_arErr  = |(s_axi.S_AXI_ARADDR >> UPPER_LSB);
`else
   assign w_cmtErr = 1'b0;
   assign w_arErr  = 1'b0;
`endif

   // PROT and the byte-offset address bits carry no meaning here.
   assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_ARADDR, w_cmtAddr};

   assign s_axi.S_AXI_AWREADY = w_awReady;
   assign s_axi.S_AXI_WREADY  = w_wReady;
   assign s_axi.S_AXI_BVALID  = r_bValid;
   assign s_axi.S_AXI_BRESP   = r_bResp;
   assign s_axi.S_AXI_ARREADY = w_arReady;
   assign s_axi.S_AXI_RVALID  = r_rValid;
   assign s_axi.S_AXI_RRESP   = r_rResp;
   assign s_axi.S_AXI_RDATA   = r_rData;
   assign wr_pulse            = r_wrPulse;

   // Flattens the register array onto the exported bus.
   always_comb begin
      reg_q = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_q[32*i +: 32] = r_regs[i];
      end
   end

   // Goes high on the first edge after reset release and stays there.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_rstDone <= 1'b0;
      end else begin
         r_rstDone <= 1'b1;
      end
   end

   // Write channel: one-entry AW and W holding registers, commit into the
   // register file, B response held until BREADY. A commit can never
   // coincide with a pending B because both READYs are low while BVALID.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_awCaptured <= 1'b0;
         r_awAddr     <= '0;
         r_wCaptured  <= 1'b0;
         r_wData      <= '0;
         r_wStrb      <= '0;
         r_bValid     <= 1'b0;
         r_bResp      <= OKAY;
         r_wrPulse    <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         r_wrPulse <= '0;
         if (r_bValid && s_axi.S_AXI_BREADY) begin
            r_bValid <= 1'b0;
         end
         if (w_commit) begin
            r_awCaptured <= 1'b0;
            r_wCaptured  <= 1'b0;
            r_bValid     <= 1'b1;
            if (w_cmtErr) begin
               r_bResp <= SLVERR;
            end else begin
               r_bResp             <= OKAY;
               r_regs[w_cmtIdx]    <= strb_merge(r_regs[w_cmtIdx], w_cmtData, w_cmtStrb);
               r_wrPulse[w_cmtIdx] <= 1'b1;
            end
         end else begin
            if (w_awHs) begin
               r_awCaptured <= 1'b1;
               r_awAddr     <= s_axi.S_AXI_AWADDR;
            end
            if (w_wHs) begin
               r_wCaptured <= 1'b1;
               r_wData     <= s_axi.S_AXI_WDATA;
               r_wStrb     <= s_axi.S_AXI_WSTRB;
            end
         end
      end
   end

   // Read channel: registers RDATA on the AR handshake. Sampling r_regs
   // here sees the pre-write value if a commit lands on the same edge.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_rValid <= 1'b0;
         r_rResp  <= OKAY;
         r_rData  <= '0;
      end else if (w_arHs) begin
         r_rValid <= 1'b1;
         if (w_arErr) begin
            r_rResp <= SLVERR;
            r_rData <= DECERR_DATA;
         end else begin
            r_rResp <= OKAY;
            r_rData <= r_regs[w_arIdx];
         end
      end else if (r_rValid && s_axi.S_AXI_RREADY) begin
         r_rValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_justtest1_axil_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_justtest1_axil_slave_regs
// Directed bench for the AXI4-Lite slave register file. A word-level model
// of the register file tracks expected contents and write pulses; a compare
// process checks reg_q/wr_pulse against it every cycle, and the bus tasks
// check handshakes and responses. Built with a 5-bit address so address
// 0x10 exercises aliasing (default) or the error response (with
// JUSTTEST1_AXIL_DECERR_EN).
// ---------------------------------------------------------------------------
module tb_justtest1_axil_slave_regs;
   import justtest1_axil_pkg::*;

   localparam int AW = 5;
   localparam int NR = 4;

   logic              aclk;
   logic              aresetn;
   logic [NR*32-1:0]  reg_q;
   logic [NR-1:0]     wr_pulse;

   justtest1_axil_slave_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) sif ();

   justtest1_axil_slave_regs #(
      .C_S_AXI_DATA_WIDTH(32),
      .C_S_AXI_ADDR_WIDTH(AW),
      .NUM_REGS(NR)
   ) dut (
      .ACLK(aclk),
      .ARESETN(aresetn),
      .s_axi(sif),
      .reg_q(reg_q),
      .wr_pulse(wr_pulse)
   );

   int errors = 0;
   int checks = 0;

   logic [31:0] modelRegs [NR];
   logic [NR-1:0] expPulse;
   bit cmpEn = 0;

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got timeout, expected handshake", name);
   endtask

   // Model: plain word array indexed by (byte address / 4) mod NR.
   function automatic int modelIdx(input logic [AW-1:0] a);
      return (int'(a) / 4) % NR;
   endfunction

   function automatic bit modelErr(input logic [AW-1:0] a);
`ifdef JUSTTEST1_AXIL_DECERR_EN
      return int'(a) >= 4 * NR;
`else
      return (int'(a) < 0);
`endif
   endfunction

   function automatic logic [31:0] modelRead(input logic [AW-1:0] a);
      return modelErr(a) ? 32'hDEAD_BEEF : modelRegs[modelIdx(a)];
   endfunction

   function automatic logic [1:0] modelResp(input logic [AW-1:0] a);
      return modelErr(a) ? 2'b10 : 2'b00;
   endfunction

   task automatic modelWrite(input logic [AW-1:0] a, input logic [31:0] d,
                             input logic [3:0] s);
      if (!modelErr(a)) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) modelRegs[modelIdx(a)][8*b +: 8] = d[8*b +: 8];
         end
         expPulse = NR'(1) << modelIdx(a);
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < NR; i++) modelRegs[i] = '0;
      expPulse = '0;
   endtask

   // Compares the exported register image and write pulses every cycle.
   always @(negedge aclk) begin
      if (cmpEn) begin
         for (int i = 0; i < NR; i++) begin
            checkOutput($sformatf("reg_q[%0d]", i), reg_q[32*i +: 32], modelRegs[i]);
         end
         checkOutput("wr_pulse", wr_pulse, expPulse);
      end
   end

   // Starts and ends just after a rising edge. AW and W valids are raised
   // after their own delays; B is held off for bHold cycles.
   task automatic writeReg(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int awDelay,
                           input int wDelay, input int bHold);
      bit awDone = 0;
      bit wDone = 0;
      bit awHs, wHs;
      int cyc = 0;
      int k = 0;
      logic [1:0] expResp;
      sif.S_AXI_AWADDR = addr;
      sif.S_AXI_WDATA  = data;
      sif.S_AXI_WSTRB  = strb;
      sif.S_AXI_BREADY = 1'b0;
      while (!(awDone && wDone) && cyc < 50) begin
         sif.S_AXI_AWVALID = !awDone && (cyc >= awDelay);
         sif.S_AXI_WVALID  = !wDone && (cyc >= wDelay);
         @(negedge aclk);
         awHs = sif.S_AXI_AWVALID && sif.S_AXI_AWREADY;
         wHs  = sif.S_AXI_WVALID && sif.S_AXI_WREADY;
         checkOutput("bvalidEarly", sif.S_AXI_BVALID, 1'b0);
         if (awDone) checkOutput("awreadyHeld", sif.S_AXI_AWREADY, 1'b0);
         if (wDone) checkOutput("wreadyHeld", sif.S_AXI_WREADY, 1'b0);
         @(posedge aclk); #1;
         if (awHs) awDone = 1;
         if (wHs) wDone = 1;
         cyc++;
      end
      sif.S_AXI_AWVALID = 1'b0;
      sif.S_AXI_WVALID  = 1'b0;
      if (!(awDone && wDone)) begin
         timeoutFail("writeHandshake");
         return;
      end
      expResp = modelResp(addr);
      modelWrite(addr, data, strb);
      sif.S_AXI_BREADY = (bHold == 0);
      forever begin
         @(negedge aclk);
         checkOutput("bvalid", sif.S_AXI_BVALID, 1'b1);
         checkOutput("bresp", sif.S_AXI_BRESP, expResp);
         checkOutput("awreadyBusy", sif.S_AXI_AWREADY, 1'b0);
         checkOutput("wreadyBusy", sif.S_AXI_WREADY, 1'b0);
         if (sif.S_AXI_BREADY) break;
         @(posedge aclk); #1;
         expPulse = '0;
         k++;
         if (k >= bHold) sif.S_AXI_BREADY = 1'b1;
      end
      @(posedge aclk); #1;
      expPulse = '0;
      sif.S_AXI_BREADY = 1'b0;
      @(negedge aclk);
      checkOutput("bvalidDrop", sif.S_AXI_BVALID, 1'b0);
      checkOutput("awreadyBack", sif.S_AXI_AWREADY, 1'b1);
      checkOutput("wreadyBack", sif.S_AXI_WREADY, 1'b1);
      @(posedge aclk); #1;
   endtask

   task automatic readReg(input logic [AW-1:0] addr, input int rHold,
                          output logic [31:0] gotData, output logic [1:0] gotResp);
      bit hs = 0;
      int cyc = 0;
      int k = 0;
      logic [31:0] expData;
      logic [1:0] expRespV;
      gotData = '0;
      gotResp = '0;
      expData = '0;
      expRespV = '0;
      sif.S_AXI_ARADDR  = addr;
      sif.S_AXI_ARVALID = 1'b1;
      while (!hs && cyc < 50) begin
         @(negedge aclk);
         if (sif.S_AXI_ARREADY) begin
            hs = 1;
            expData  = modelRead(addr);
            expRespV = modelResp(addr);
         end
         @(posedge aclk); #1;
         cyc++;
      end
      sif.S_AXI_ARVALID = 1'b0;
      if (!hs) begin
         timeoutFail("readHandshake");
         return;
      end
      sif.S_AXI_RREADY = (rHold == 0);
      forever begin
         @(negedge aclk);
         checkOutput("rvalid", sif.S_AXI_RVALID, 1'b1);
         checkOutput("rdata", sif.S_AXI_RDATA, expData);
         checkOutput("rresp", sif.S_AXI_RRESP, expRespV);
         checkOutput("arreadyBusy", sif.S_AXI_ARREADY, 1'b0);
         gotData = sif.S_AXI_RDATA;
         gotResp = sif.S_AXI_RRESP;
         if (sif.S_AXI_RREADY) break;
         @(posedge aclk); #1;
         k++;
         if (k >= rHold) sif.S_AXI_RREADY = 1'b1;
      end
      @(posedge aclk); #1;
      sif.S_AXI_RREADY = 1'b0;
      @(negedge aclk);
      checkOutput("rvalidDrop", sif.S_AXI_RVALID, 1'b0);
      checkOutput("arreadyBack", sif.S_AXI_ARREADY, 1'b1);
      @(posedge aclk); #1;
   endtask

   task automatic checkIdleAfterReset(input string tag);
      checkOutput({tag, "_awready"}, sif.S_AXI_AWREADY, 1'b0);
      checkOutput({tag, "_wready"}, sif.S_AXI_WREADY, 1'b0);
      checkOutput({tag, "_arready"}, sif.S_AXI_ARREADY, 1'b0);
      checkOutput({tag, "_bvalid"}, sif.S_AXI_BVALID, 1'b0);
      checkOutput({tag, "_rvalid"}, sif.S_AXI_RVALID, 1'b0);
      checkOutput({tag, "_wr_pulse"}, wr_pulse, '0);
      for (int i = 0; i < NR; i++) begin
         checkOutput($sformatf("%s_reg%0d", tag, i), reg_q[32*i +: 32], 32'h0);
      end
   endtask

   task automatic applyStimulus();
      logic [31:0] got;
      logic [1:0] gotResp;
      logic [31:0] oldReg0;

      // Reset state and READY rise on the first edge after release
      @(negedge aclk);
      checkIdleAfterReset("reset");
      checkOutput("reset_bresp", sif.S_AXI_BRESP, 2'b00);
      checkOutput("reset_rresp", sif.S_AXI_RRESP, 2'b00);
      checkOutput("reset_rdata", sif.S_AXI_RDATA, 32'h0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      modelClear();
      cmpEn = 1;
      @(negedge aclk);
      checkOutput("preEdge_awready", sif.S_AXI_AWREADY, 1'b0);
      @(posedge aclk); #1;
      checkOutput("postEdge_awready", sif.S_AXI_AWREADY, 1'b1);
      checkOutput("postEdge_wready", sif.S_AXI_WREADY, 1'b1);
      checkOutput("postEdge_arready", sif.S_AXI_ARREADY, 1'b1);

      // Four-word write then readback
      for (int i = 0; i < 4; i++) writeReg(AW'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         readReg(AW'(4 * i), 0, got, gotResp);
         checkOutput($sformatf("readback%0d", i), got, 32'(i + 1));
         checkOutput($sformatf("readbackResp%0d", i), gotResp, 2'b00);
      end

      // Byte strobes
      writeReg(5'h04, 32'hAABB_CCDD, 4'hF, 0, 0, 0);
      writeReg(5'h04, 32'h1122_3344, 4'b0101, 0, 0, 0);
      readReg(5'h04, 0, got, gotResp);
      checkOutput("strbMerge", got, 32'hAA22_CC44);

      // AW ahead of W, then W ahead of AW
      writeReg(5'h0C, 32'hC0FF_EE01, 4'hF, 0, 3, 0);
      writeReg(5'h00, 32'h1234_5678, 4'hF, 3, 0, 0);
      readReg(5'h0C, 0, got, gotResp);
      checkOutput("awFirst", got, 32'hC0FF_EE01);
      readReg(5'h00, 0, got, gotResp);
      checkOutput("wFirst", got, 32'h1234_5678);

      // Back-pressure on B and R
      writeReg(5'h04, 32'h0BAD_F00D, 4'hF, 0, 0, 5);
      readReg(5'h04, 5, got, gotResp);
      checkOutput("heldRead", got, 32'h0BAD_F00D);

      // Read and write to the same register on the same edge
      writeReg(5'h08, 32'h3, 4'hF, 0, 0, 0);
      fork
         writeReg(5'h08, 32'h9, 4'hF, 0, 0, 0);
         readReg(5'h08, 0, got, gotResp);
      join
      checkOutput("sameCycleOld", got, 32'h3);
      readReg(5'h08, 0, got, gotResp);
      checkOutput("sameCycleNew", got, 32'h9);

      // Zero strobe still responds and pulses but leaves data alone
      writeReg(5'h0C, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
      readReg(5'h0C, 0, got, gotResp);
      checkOutput("zeroStrb", got, 32'hC0FF_EE01);

      // Address above the register window
      oldReg0 = modelRegs[0];
      writeReg(5'h10, 32'h5A5A_5A5A, 4'hF, 0, 0, 0);
      readReg(5'h10, 0, got, gotResp);
`ifdef JUSTTEST1_AXIL_DECERR_EN
      checkOutput("decerrData", got, 32'hDEAD_BEEF);
      checkOutput("decerrResp", gotResp, 2'b10);
      readReg(5'h00, 0, got, gotResp);
      checkOutput("decerrReg0Kept", got, oldReg0);
`else
      checkOutput("aliasData", got, 32'h5A5A_5A5A);
      checkOutput("aliasResp", gotResp, 2'b00);
      readReg(5'h00, 0, got, gotResp);
      checkOutput("aliasReg0", got, 32'h5A5A_5A5A);
`endif

      // Reset while BVALID is pending
      sif.S_AXI_AWADDR  = 5'h04;
      sif.S_AXI_WDATA   = 32'h7777_7777;
      sif.S_AXI_WSTRB   = 4'hF;
      sif.S_AXI_AWVALID = 1'b1;
      sif.S_AXI_WVALID  = 1'b1;
      sif.S_AXI_BREADY  = 1'b0;
      @(negedge aclk);
      checkOutput("midRst_awready", sif.S_AXI_AWREADY, 1'b1);
      @(posedge aclk); #1;
      sif.S_AXI_AWVALID = 1'b0;
      sif.S_AXI_WVALID  = 1'b0;
      modelWrite(5'h04, 32'h7777_7777, 4'hF);
      @(negedge aclk);
      checkOutput("midRst_bvalidBefore", sif.S_AXI_BVALID, 1'b1);
      #2;
      aresetn = 1'b0;
      modelClear();
      #1;
      checkIdleAfterReset("midRst");
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      checkOutput("midRst_preEdge_arready", sif.S_AXI_ARREADY, 1'b0);
      @(posedge aclk); #1;
      checkOutput("midRst_postEdge_awready", sif.S_AXI_AWREADY, 1'b1);
      checkOutput("midRst_postEdge_wready", sif.S_AXI_WREADY, 1'b1);
      checkOutput("midRst_postEdge_arready", sif.S_AXI_ARREADY, 1'b1);
      readReg(5'h04, 0, got, gotResp);
      checkOutput("midRst_reg1", got, 32'h0);
   endtask

   initial begin
      aresetn = 1'b0;
      sif.S_AXI_AWADDR  = '0;
      sif.S_AXI_AWPROT  = '0;
      sif.S_AXI_AWVALID = 1'b0;
      sif.S_AXI_WDATA   = '0;
      sif.S_AXI_WSTRB   = '0;
      sif.S_AXI_WVALID  = 1'b0;
      sif.S_AXI_BREADY  = 1'b0;
      sif.S_AXI_ARADDR  = '0;
      sif.S_AXI_ARPROT  = '0;
      sif.S_AXI_ARVALID = 1'b0;
      sif.S_AXI_RREADY  = 1'b0;
      modelClear();
      applyStimulus();
      cmpEn = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop in case a sequence wedges somewhere unbounded.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
